// File: rtl/rv_dmem_responder.sv
// rtl/rv_dmem_responder.sv - wait-state data memory responder with a read-only instruction port
// Define RV_DMEM_RESP_RANGE_CHECK_EN to flag and suppress accesses beyond the RAM.
module rv_dmem_responder #(
  parameter int g_addr_width  = 12,
  parameter int g_wait_states = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
  output logic        range_err_o,
`endif
  output logic        proto_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         DEPTH  = 1 << g_addr_width;

  logic [31:0]             mem_q [DEPTH];
  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    proto_err_q, proto_err_d;
  logic [g_addr_width-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              sel_q;
  logic                    store_q;
  logic                    oor_q;
  logic                    oor_in;
  logic [31:0]             im_data_q;
  logic                    im_valid_q;
  logic [31:0]             data_l_q;
  logic                    req;
  logic                    accept;
  logic                    access;
  logic                    unused_addr_bits;

  assign req    = dm_load_i | dm_store_i;
  assign accept = (state_q == S_IDLE) & req;
  assign access = (state_q == S_BUSY) & (cnt_q == 4'd0);

`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
  assign oor_in      = |dm_addr_i[31:g_addr_width+2];
  assign range_err_o = (state_q == S_DONE) & oor_q;
`else
  assign oor_in = 1'b0;
`endif

  assign unused_addr_bits = ^{im_addr_i[31:g_addr_width+2], im_addr_i[1:0],
                              dm_addr_i[31:g_addr_width+2], dm_addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    // Strobes while not ready are dropped; both strobes at accept resolve to a store.
    proto_err_d = proto_err_q | (accept & dm_load_i & dm_store_i)
                              | ((state_q != S_IDLE) & req);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = 4'(g_wait_states);
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      proto_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      store_q     <= 1'b0;
      oor_q       <= 1'b0;
      im_data_q   <= 32'h0;
      im_valid_q  <= 1'b0;
      data_l_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      im_data_q   <= mem_q[im_addr_i[g_addr_width+1:2]];
      im_valid_q  <= 1'b1;
      if (accept) begin
        addr_q  <= dm_addr_i[g_addr_width+1:2];
        wdata_q <= dm_data_s_i;
        sel_q   <= dm_data_select_i;
        store_q <= dm_store_i;
        oor_q   <= oor_in;
      end
      if (access && !store_q) data_l_q <= oor_q ? 32'h0 : mem_q[addr_q];
    end
  end

  // RAM is not reset; an async reset leaves state_q in IDLE so a pending write never fires.
  always_ff @(posedge clk_i) begin
    if (access && store_q && !oor_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign dm_ready_o      = (state_q == S_IDLE);
  assign dm_load_done_o  = (state_q == S_DONE) & ~store_q;
  assign dm_store_done_o = (state_q == S_DONE) & store_q;
  assign dm_data_l_o     = data_l_q;
  assign im_data_o       = im_data_q;
  assign im_valid_o      = im_valid_q;
  assign proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// tb/tb_rv_dmem_responder.sv - checks two responders (0 and 3 wait states) against a word-array model
module tb_rv_dmem_responder;
  localparam int AW = 12;
  localparam int LAT [2] = '{2, 5};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr, dm_addr, dm_data_s;
  logic [3:0]  sel;
  logic        ld, st;
  logic [31:0] im_data [2];
  logic        im_valid [2];
  logic        ready [2];
  logic [31:0] data_l [2];
  logic        load_done [2];
  logic        store_done [2];
  logic        proto_err [2];
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
  logic        range_err [2];
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [1 << AW];
  logic [31:0] last_l = 32'h0;
  bit          pe_model = 1'b0;

  always #5 clk = ~clk;

  rv_dmem_responder #(.g_addr_width(AW), .g_wait_states(0)) u_w0 (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr), .im_data_o(im_data[0]),
    .im_valid_o(im_valid[0]), .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s),
    .dm_data_select_i(sel), .dm_load_i(ld), .dm_store_i(st), .dm_ready_o(ready[0]),
    .dm_data_l_o(data_l[0]), .dm_load_done_o(load_done[0]), .dm_store_done_o(store_done[0]),
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
    .range_err_o(range_err[0]),
`endif
    .proto_err_o(proto_err[0]));

  rv_dmem_responder #(.g_addr_width(AW), .g_wait_states(3)) u_w3 (
    .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(im_addr), .im_data_o(im_data[1]),
    .im_valid_o(im_valid[1]), .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s),
    .dm_data_select_i(sel), .dm_load_i(ld), .dm_store_i(st), .dm_ready_o(ready[1]),
    .dm_data_l_o(data_l[1]), .dm_load_done_o(load_done[1]), .dm_store_done_o(store_done[1]),
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
    .range_err_o(range_err[1]),
`endif
    .proto_err_o(proto_err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from an idle responder pair, checked cycle by cycle for 7 cycles after accept.
  task automatic do_req(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sl, input bit poke);
    int          widx;
    bit          oor;
    bit          hit;
    logic [31:0] prev_l, new_l;
    widx = int'(a[AW+1:2]);
    oor  = 1'b0;
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
    oor = (a[31:AW+2] != '0);
`endif
    prev_l = last_l;
    new_l  = s ? last_l : (oor ? 32'h0 : ref_mem[widx]);
    @(negedge clk);
    dm_addr = a; dm_data_s = d; sel = sl; ld = l; st = s;
    @(posedge clk);
    #1;
    ld = 1'b0; st = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (poke) ld = (k == 1);
      for (int u = 0; u < 2; u++) begin
        hit = (k == LAT[u]);
        chk($sformatf("load_done u%0d k%0d", u, k), 32'(load_done[u]), 32'(hit && !s));
        chk($sformatf("store_done u%0d k%0d", u, k), 32'(store_done[u]), 32'(hit && s));
        chk($sformatf("ready u%0d k%0d", u, k), 32'(ready[u]), 32'(k > LAT[u]));
        chk($sformatf("data_l u%0d k%0d", u, k), data_l[u], (k >= LAT[u]) ? new_l : prev_l);
`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
        chk($sformatf("range_err u%0d k%0d", u, k), 32'(range_err[u]), 32'(hit && oor));
`endif
      end
    end
    last_l = new_l;
    if (s && !oor)
      for (int b = 0; b < 4; b++)
        if (sl[b]) ref_mem[widx][8*b +: 8] = d[8*b +: 8];
    pe_model = pe_model | (l && s) | poke;
    for (int u = 0; u < 2; u++)
      chk($sformatf("proto_err u%0d", u), 32'(proto_err[u]), 32'(pe_model));
  endtask

  task automatic im_chk(input logic [31:0] a);
    @(negedge clk);
    im_addr = a;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("im_valid u%0d", u), 32'(im_valid[u]), 32'h1);
      chk($sformatf("im_data u%0d a=%h", u, a), im_data[u], ref_mem[int'(a[AW+1:2])]);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; im_addr = 32'h0; dm_addr = 32'h0; dm_data_s = 32'h0;
    sel = 4'h0; ld = 1'b0; st = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst ready", 32'(ready[u]), 32'h1);
      chk("rst load_done", 32'(load_done[u]), 32'h0);
      chk("rst store_done", 32'(store_done[u]), 32'h0);
      chk("rst data_l", data_l[u], 32'h0);
      chk("rst im_data", im_data[u], 32'h0);
      chk("rst im_valid", 32'(im_valid[u]), 32'h0);
      chk("rst proto_err", 32'(proto_err[u]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk("im_valid after release", 32'(im_valid[u]), 32'h1);

    do_req(0, 1, 32'h40, 32'h12345678, 4'b1111, 0);
    do_req(1, 0, 32'h40, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("full word load", data_l[u], 32'h12345678);
    do_req(0, 1, 32'h40, 32'hAABBCCDD, 4'b0010, 0);
    do_req(1, 0, 32'h40, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("byte lane merge", data_l[u], 32'h1234CC78);
    do_req(0, 1, 32'h40, 32'hFFFFFFFF, 4'b0000, 0);
    do_req(1, 0, 32'h40, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("empty select", data_l[u], 32'h1234CC78);
    do_req(0, 1, 32'h80, 32'hCAFEF00D, 4'b1111, 0);

    do_req(1, 0, 32'h40, 32'h0, 4'h0, 1);
    do_req(1, 1, 32'h44, 32'h55667788, 4'b1111, 0);
    do_req(1, 0, 32'h44, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("dual strobe store", data_l[u], 32'h55667788);

    for (int i = 0; i < 8; i++) do_req(0, 1, 32'h200 + 32'(4 * i), $urandom, 4'b1111, 0);
    for (int i = 0; i < 40; i++) begin
      a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
`ifndef RV_DMEM_RESP_RANGE_CHECK_EN
      a = a | (32'($urandom_range(0, 3)) << (AW + 2));
`endif
      if ($urandom_range(0, 1) == 1) do_req(0, 1, a, $urandom, 4'($urandom_range(0, 15)), 0);
      else                           do_req(1, 0, a, 32'h0, 4'h0, 0);
      im_chk(32'h200 + 32'(4 * $urandom_range(0, 7)));
    end

    @(negedge clk);
    dm_addr = 32'h80; dm_data_s = 32'h0BADBEEF; sel = 4'b1111; st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("abort ready", 32'(ready[u]), 32'h1);
      chk("abort data_l", data_l[u], 32'h0);
    end
    last_l = 32'h0;
    pe_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        chk("abort no store_done", 32'(store_done[u]), 32'h0);
        chk("abort no load_done", 32'(load_done[u]), 32'h0);
        chk("abort proto_err", 32'(proto_err[u]), 32'h0);
      end
    end
    do_req(1, 0, 32'h80, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("aborted store skipped", data_l[u], 32'hCAFEF00D);
    im_chk(32'h40);
    for (int u = 0; u < 2; u++) chk("im fetch after reset", im_data[u], 32'h1234CC78);

`ifdef RV_DMEM_RESP_RANGE_CHECK_EN
    do_req(0, 1, 32'h0, 32'h01020304, 4'b1111, 0);
    do_req(0, 1, 32'h4000, 32'h11111111, 4'b1111, 0);
    do_req(1, 0, 32'h0, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("oor store suppressed", data_l[u], 32'h01020304);
    do_req(1, 0, 32'h4000, 32'h0, 4'h0, 0);
    for (int u = 0; u < 2; u++) chk("oor load zero", data_l[u], 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
